// File: rtl/wrr_scheduler.sv
// Weighted round-robin arbiter between two requesters and a shared resource, with in-flight credit tracking.
// One-cycle grant-to-issue latency; a requester stalls while it is not granted or the resource is full.
module wrr_scheduler #(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int ID_WIDTH        = 8,
  parameter int WEIGHT_1        = 2,
  parameter int WEIGHT_2        = 1,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid_1,
  input  logic [ADDRESS_WIDTH-1:0] in_address_1,
  input  logic [ID_WIDTH-1:0]      in_id_1,
  output logic                     out_stall_1,
  input  logic                     in_valid_2,
  input  logic [ADDRESS_WIDTH-1:0] in_address_2,
  input  logic [ID_WIDTH-1:0]      in_id_2,
  output logic                     out_stall_2,
  input  logic                     in_resp_valid,
  output logic                     out_issue,
  output logic [ADDRESS_WIDTH-1:0] out_address,
  output logic [ID_WIDTH-1:0]      out_id,
  output logic                     out_choice,
  output logic [3:0]               out_outstanding,
  output logic                     out_error
);

  typedef enum logic {OWN_1 = 1'b0, OWN_2 = 1'b1} owner_t;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] address;
    logic [ID_WIDTH-1:0]      id;
  } req_t;

  owner_t     owner, owner_nxt;
  logic [2:0] burst, burst_nxt;
  logic [3:0] count;
  logic       eligible, owner_vld, other_vld;
  logic       pick_owner, pick_other;
  logic       grant_1, grant_2, grant;
  logic [2:0] owner_weight;
  req_t       req_sel;

  // Credits are charged at grant time, so eligibility only looks at the registered count.
  assign eligible     = count < 4'(MAX_OUTSTANDING);
  assign owner_vld    = (owner == OWN_1) ? in_valid_1 : in_valid_2;
  assign other_vld    = (owner == OWN_1) ? in_valid_2 : in_valid_1;
  assign owner_weight = (owner == OWN_1) ? 3'(WEIGHT_1) : 3'(WEIGHT_2);

  always_comb begin
    pick_owner = 1'b0;
    pick_other = 1'b0;
    owner_nxt  = owner;
    burst_nxt  = burst;
    if (eligible) begin
      if (owner_vld && (burst < owner_weight)) begin
        pick_owner = 1'b1;
        burst_nxt  = (burst == 3'd7) ? burst : burst + 3'd1;
      end else if (other_vld) begin
        pick_other = 1'b1;
        owner_nxt  = (owner == OWN_1) ? OWN_2 : OWN_1;
        burst_nxt  = 3'd1;
      end else if (owner_vld) begin
        // Turn exhausted but nobody else wants the resource: start a fresh turn.
        pick_owner = 1'b1;
        burst_nxt  = 3'd1;
      end
    end
  end

  assign grant_1 = (pick_owner && (owner == OWN_1)) || (pick_other && (owner == OWN_2));
  assign grant_2 = (pick_owner && (owner == OWN_2)) || (pick_other && (owner == OWN_1));
  assign grant   = grant_1 | grant_2;

  assign req_sel = grant_1 ? req_t'{address: in_address_1, id: in_id_1}
                           : req_t'{address: in_address_2, id: in_id_2};

  assign out_stall_1     = in_valid_1 & ~grant_1;
  assign out_stall_2     = in_valid_2 & ~grant_2;
  assign out_outstanding = count;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner       <= OWN_1;
      burst       <= 3'd0;
      count       <= 4'd0;
      out_issue   <= 1'b0;
      out_address <= '0;
      out_id      <= '0;
      out_choice  <= 1'b1;
      out_error   <= 1'b0;
    end else begin
      owner     <= owner_nxt;
      burst     <= burst_nxt;
      out_issue <= grant;
      if (grant) begin
        out_address <= req_sel.address;
        out_id      <= req_sel.id;
        out_choice  <= grant_1;
      end
      if (grant && !in_resp_valid) begin
        count <= count + 4'd1;
      end else if (!grant && in_resp_valid) begin
        if (count == 4'd0) out_error <= 1'b1;
        else               count     <= count - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_wrr_scheduler.sv
// Table-driven bench for wrr_scheduler with an issue scoreboard fed from the expected grants.
module tb_wrr_scheduler;

  localparam int AW = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid_1, in_valid_2, in_resp_valid;
  logic [AW-1:0] in_address_1, in_address_2;
  logic [IW-1:0] in_id_1, in_id_2;
  logic          out_stall_1, out_stall_2;
  logic          out_issue, out_choice, out_error;
  logic [AW-1:0] out_address;
  logic [IW-1:0] out_id;
  logic [3:0]    out_outstanding;

  wrr_scheduler #(
    .ADDRESS_WIDTH(AW), .ID_WIDTH(IW), .WEIGHT_1(2), .WEIGHT_2(1), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid_1(in_valid_1), .in_address_1(in_address_1), .in_id_1(in_id_1), .out_stall_1(out_stall_1),
    .in_valid_2(in_valid_2), .in_address_2(in_address_2), .in_id_2(in_id_2), .out_stall_2(out_stall_2),
    .in_resp_valid(in_resp_valid),
    .out_issue(out_issue), .out_address(out_address), .out_id(out_id), .out_choice(out_choice),
    .out_outstanding(out_outstanding), .out_error(out_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, v1, v2, resp;
    logic       s1, s2;
    logic [3:0] cnt;
    logic       err;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
    logic          choice;
  } iss_t;

  vec_t vecs[$];
  iss_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ins = {rst, v1, v2, resp}; st = {stall_1, stall_2}; cnt/err = values seen before the edge
  task automatic add(input logic [3:0] ins, input logic [1:0] st, input int cnt, input logic err);
    vec_t v;
    v.rst = ins[3]; v.v1 = ins[2]; v.v2 = ins[1]; v.resp = ins[0];
    v.s1 = st[1]; v.s2 = st[0]; v.cnt = 4'(cnt); v.err = err;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic prev_rst;
    iss_t e;

    // Weights 2/1, both valid, responses every cycle after the first grant
    add(4'b0110, 2'b01, 0, 0);
    add(4'b0111, 2'b01, 1, 0);
    add(4'b0111, 2'b10, 1, 0);
    add(4'b0111, 2'b01, 1, 0);
    add(4'b0111, 2'b01, 1, 0);
    add(4'b0111, 2'b10, 1, 0);
    add(4'b0001, 2'b00, 1, 0);
    add(4'b0000, 2'b00, 0, 0);
    add(4'b1000, 2'b00, 0, 0);
    // Only requester 2, six grants
    add(4'b0010, 2'b00, 0, 0);
    for (int k = 0; k < 5; k++) add(4'b0011, 2'b00, 1, 0);
    add(4'b0001, 2'b00, 1, 0);
    add(4'b0000, 2'b00, 0, 0);
    add(4'b1000, 2'b00, 0, 0);
    // Fill to MAX_OUTSTANDING, one response frees exactly one grant, then grant+response at count 2
    add(4'b0100, 2'b00, 0, 0);
    add(4'b0100, 2'b00, 1, 0);
    add(4'b0100, 2'b00, 2, 0);
    add(4'b0100, 2'b00, 3, 0);
    add(4'b0100, 2'b10, 4, 0);
    add(4'b0101, 2'b10, 4, 0);
    add(4'b0100, 2'b00, 3, 0);
    add(4'b0100, 2'b10, 4, 0);
    add(4'b0001, 2'b00, 4, 0);
    add(4'b0001, 2'b00, 3, 0);
    add(4'b0101, 2'b00, 2, 0);
    add(4'b0000, 2'b00, 2, 0);
    add(4'b0001, 2'b00, 2, 0);
    add(4'b0001, 2'b00, 1, 0);
    add(4'b0000, 2'b00, 0, 0);
    // Response with count 0 raises a sticky error cleared only by reset
    add(4'b0001, 2'b00, 0, 0);
    add(4'b0000, 2'b00, 0, 1);
    add(4'b0100, 2'b00, 0, 1);
    add(4'b0001, 2'b00, 1, 1);
    add(4'b0000, 2'b00, 0, 1);
    add(4'b1000, 2'b00, 0, 1);
    add(4'b0000, 2'b00, 0, 0);
    // Reset in the middle of a 1,1,2 sequence at count 3, then restart at requester 1
    add(4'b0110, 2'b01, 0, 0);
    add(4'b0110, 2'b01, 1, 0);
    add(4'b0110, 2'b10, 2, 0);
    add(4'b1000, 2'b00, 3, 0);
    add(4'b0110, 2'b01, 0, 0);
    add(4'b0110, 2'b01, 1, 0);
    add(4'b0110, 2'b10, 2, 0);
    add(4'b0001, 2'b00, 3, 0);
    add(4'b0001, 2'b00, 2, 0);
    add(4'b0001, 2'b00, 1, 0);
    add(4'b0000, 2'b00, 0, 0);

    reset = 1'b1;
    in_valid_1 = 1'b0; in_valid_2 = 1'b0; in_resp_valid = 1'b0;
    in_address_1 = '0; in_address_2 = '0; in_id_1 = '0; in_id_2 = '0;
    repeat (2) @(posedge clk);
    prev_rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      reset         = vecs[i].rst;
      in_valid_1    = vecs[i].v1;
      in_valid_2    = vecs[i].v2;
      in_resp_valid = vecs[i].resp;
      in_address_1  = AW'($urandom);
      in_address_2  = AW'($urandom);
      in_id_1       = IW'($urandom);
      in_id_2       = IW'($urandom);
      @(negedge clk);
      if (prev_rst) begin
        check($sformatf("v%0d reset issue", i), 32'(out_issue), 32'd0);
        check($sformatf("v%0d reset choice", i), 32'(out_choice), 32'd1);
        check($sformatf("v%0d reset address", i), 32'(out_address), 32'd0);
        check($sformatf("v%0d reset id", i), 32'(out_id), 32'd0);
      end else if (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("v%0d issue", i), 32'(out_issue), 32'd1);
        check($sformatf("v%0d address", i), 32'(out_address), 32'(e.addr));
        check($sformatf("v%0d id", i), 32'(out_id), 32'(e.id));
        check($sformatf("v%0d choice", i), 32'(out_choice), 32'(e.choice));
      end else begin
        check($sformatf("v%0d idle issue", i), 32'(out_issue), 32'd0);
      end
      check($sformatf("v%0d stall_1", i), 32'(out_stall_1), 32'(vecs[i].s1));
      check($sformatf("v%0d stall_2", i), 32'(out_stall_2), 32'(vecs[i].s2));
      check($sformatf("v%0d outstanding", i), 32'(out_outstanding), 32'(vecs[i].cnt));
      check($sformatf("v%0d error", i), 32'(out_error), 32'(vecs[i].err));
      if (vecs[i].rst) begin
        sb.delete();
      end else begin
        if (vecs[i].v1 && !vecs[i].s1) sb.push_back('{addr: in_address_1, id: in_id_1, choice: 1'b1});
        if (vecs[i].v2 && !vecs[i].s2) sb.push_back('{addr: in_address_2, id: in_id_2, choice: 1'b0});
      end
      prev_rst = vecs[i].rst;
    end

    // Grant and response together at count 0: no error, count stays 0, one issue follows
    @(posedge clk);
    #1;
    in_valid_2 = 1'b1; in_resp_valid = 1'b1;
    in_address_2 = 16'hbeef; in_id_2 = 4'h9;
    @(negedge clk);
    check("zero grant+resp stall_2", 32'(out_stall_2), 32'd0);
    @(posedge clk);
    #1;
    in_valid_2 = 1'b0; in_resp_valid = 1'b0;
    @(negedge clk);
    check("zero grant+resp issue", 32'(out_issue), 32'd1);
    check("zero grant+resp address", 32'(out_address), 32'hbeef);
    check("zero grant+resp choice", 32'(out_choice), 32'd0);
    check("zero grant+resp count", 32'(out_outstanding), 32'd0);
    check("zero grant+resp error", 32'(out_error), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("single issue per grant", 32'(out_issue), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wrr_scheduler.md
# wrr_scheduler

Weighted round-robin scheduler between the two pipeline outputs and `shared_resource`. It chooses which requester issues each cycle and tracks requests still outstanding in the resource, so the resource is never over-subscribed. It produces per-requester stall signals and one registered request (address, id, issue strobe, choice) toward the resource. It completes responses by counting `shared_resource` `out_valid` pulses.

## Interface
- `WEIGHT_1`, default 2: max consecutive grants to requester 1 while requester 2 waits (1..7).
- `WEIGHT_2`, default 1: same for requester 2 (1..7).
- `MAX_OUTSTANDING`, default 4: max requests in flight in the resource (1..15).

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid_1`  in  1  requester 1 has a request.
- `in_address_1`  in  `ADDRESS_WIDTH`  requester 1 address.
- `in_id_1`  in  `ID_WIDTH`  requester 1 id.
- `out_stall_1`  out  1  requester 1 must hold its request.
- `in_valid_2`, `in_address_2`, `in_id_2`, `out_stall_2`: same for requester 2.
- `in_resp_valid`  in  1  the resource returned one response (its `out_valid`).
- `out_issue`  out  1  registered request strobe to the resource.
- `out_address`  out  `ADDRESS_WIDTH`  registered request address.
- `out_id`  out  `ID_WIDTH`  registered request id.
- `out_choice`  out  1  1 = issued request came from requester 1, 0 = from requester 2.
- `out_outstanding`  out  4  current in-flight count.
- `out_error`  out  1  sticky: response received with count 0.

## Operation
- State: `owner` (OWN_1/OWN_2), `burst` (3 bits, grants given to the owner in the current turn), `count` (4 bits), output registers.
- Eligibility: a grant is possible only when `count < MAX_OUTSTANDING`. If not eligible, there is no grant and `out_stall_x = in_valid_x`.
- Grant priority each cycle when eligible:
  1. Owner valid and `burst < WEIGHT_owner`: grant owner; `burst++`.
  2. Otherwise, if the other requester is valid: grant it; `owner <=` other; `burst <= 1`.
  3. Otherwise, if the owner is valid (turn used up, other idle): grant owner; `burst <= 1`.
  4. Otherwise: no grant; `owner` and `burst` hold.
- `out_stall_x = in_valid_x & ~grant_x`, combinational from current state and inputs. A requester is never granted while its `in_valid` is low.
- On grant: next edge loads `out_address` and `out_id` from the granted requester, sets `out_choice` (1 for requester 1), and sets `out_issue = 1`. With no grant, `out_issue = 0`; address, id and choice hold their last values.
- Count update per edge:
  - +1 on grant.
  - −1 on `in_resp_valid`.
  - Both in the same cycle: unchanged.
  - Response while `count == 0` and no grant: count stays 0 and `out_error <= 1`.
- `out_error` is cleared only by reset.
- `out_outstanding = count`.

## Timing
- Reset values:
  - `owner = OWN_1`, `burst = 0`, `count = 0`.
  - `out_issue = 0`, `out_address = 0`, `out_id = 0`, `out_choice = 1`, `out_error = 0`.
  - Stalls follow the combinational rule, so any asserted valid with `count = 0` is granted in the first cycle after reset.
- Latency: grant in cycle N, `out_issue` high in cycle N+1. Exactly one issue per grant. Back-to-back grants give a continuous `out_issue`.
- Credit counts at grant time, not at issue. A response in cycle N is visible in eligibility at cycle N+1; there is no same-cycle bypass.
- Full: at `count == MAX_OUTSTANDING`, stall every valid requester until a response arrives.
- Reset asserted mid-operation: all state returns to reset values at that edge. Any pending issue is dropped and in-flight responses are no longer counted. Responses arriving after reset with `count = 0` set `out_error`; the bench must quiesce the resource before reset.
- `burst` saturates at 7 and never wraps; weights are ≤ 7.

## Test plan
- Weights 2/1, both valid continuously, `in_resp_valid` pulsed every cycle:
  - grant order 1,1,2,1,1,2…
  - `out_choice` 1,1,0,1,1,0 one cycle later
  - `out_outstanding` stays at 1.
- Only requester 2 valid, 6 cycles after reset:
  - six grants to 2, `out_stall_2 = 0` throughout
  - `owner = OWN_2`, `out_choice = 0`.
- `MAX_OUTSTANDING = 4`, requester 1 valid, no responses:
  - 4 grants; `out_outstanding` reaches 4; `out_stall_1 = 1` from cycle 5.
  - One `in_resp_valid` pulse gives exactly one more grant on the following cycle.
- Count 2, grant and `in_resp_valid` in the same cycle: `out_outstanding` stays 2, `out_issue = 1` next cycle.
- `in_resp_valid` with count 0: `out_error = 1` and stays 1; count stays 0; cleared only by `reset`.
- Reset during a 1,1,2 sequence at count 3:
  - next cycle `out_issue = 0`, count 0, `out_choice = 1`
  - with both valid, grants restart at requester 1.
